// File: rtl/mult_job_arbiter_pkg.sv
// Shared definitions for the multiplier job arbiter: default widths and FSM state codes.
package mult_job_arbiter_pkg;

  localparam int DW_DEFAULT = 4;
  localparam int AW_DEFAULT = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_MULT  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    READ  = ST_READ,
    MULT  = ST_MULT,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/mult_job_arbiter_shift_add.sv
// Unsigned shift-add multiplier: one partial product per cycle, DW cycles per product.
module mult_shift_add #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [2*DW-1:0] p
);

  localparam int CW = $clog2(DW + 1);

  logic [2*DW-1:0] acc_q, mcand_q;
  logic [DW-1:0]   mplier_q;
  logic [CW-1:0]   cnt_q;

  logic [2*DW-1:0] accIn, mcIn;
  logic [DW-1:0]   mpIn;
  logic            stepEn;

  // The start cycle already performs the first iteration straight from a/b.
  always_comb begin
    accIn  = start ? '0 : acc_q;
    mcIn   = start ? {{DW{1'b0}}, a} : mcand_q;
    mpIn   = start ? b : mplier_q;
    stepEn = start || busy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (stepEn) begin
      acc_q    <= accIn + (mpIn[0] ? mcIn : '0);
      mcand_q  <= mcIn << 1;
      mplier_q <= mpIn >> 1;
      cnt_q    <= start ? CW'(DW - 1) : cnt_q - CW'(1);
    end
  end

  assign busy = (cnt_q != '0);
  assign done = start ? (DW == 1) : (cnt_q == CW'(1));
  assign p    = acc_q;

endmodule

// File: rtl/mult_job_arbiter.sv
// Round-robin job arbiter sequencing regfile read, shared multiply and RAM write for two requesters.
module mult_job_arbiter
  import mult_job_arbiter_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            req1,
  input  logic [AW-1:0]   a1_0,
  input  logic [AW-1:0]   a1_1,
  input  logic [AW-1:0]   a2_0,
  input  logic [AW-1:0]   a2_1,
  input  logic [AW-1:0]   ar_0,
  input  logic [AW-1:0]   ar_1,
  output logic            ack0,
  output logic            ack1,
  output logic [AW-1:0]   rf_adr1,
  output logic [AW-1:0]   rf_adr2,
  input  logic [DW-1:0]   rf_d1,
  input  logic [DW-1:0]   rf_d2,
  output logic            ram_we,
  output logic [AW-1:0]   ram_adr,
  output logic [2*DW-1:0] ram_wd,
  output logic [2*DW-1:0] result,
  output logic [2:0]      st_out
);

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            favour1_q, favour1_d;
  logic [AW-1:0]   jobA1_q, jobA1_d, jobA2_q, jobA2_d, jobAr_q, jobAr_d;
  logic [DW-1:0]   opA_q, opA_d, opB_q, opB_d;
  logic [2*DW-1:0] result_q, result_d;

  logic            mulStart, mulBusy, mulDone;
  logic [2*DW-1:0] mulP;

  mult_shift_add #(.DW(DW)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (mulStart),
    .a     (opA_q),
    .b     (opB_q),
    .busy  (mulBusy),
    .done  (mulDone),
    .p     (mulP)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      favour1_q <= 1'b0;
      jobA1_q   <= '0;
      jobA2_q   <= '0;
      jobAr_q   <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      favour1_q <= favour1_d;
      jobA1_q   <= jobA1_d;
      jobA2_q   <= jobA2_d;
      jobAr_q   <= jobAr_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      result_q  <= result_d;
    end
  end

  // The job register is loaded on the IDLE->GRANT edge so the regfile addresses are valid from GRANT on.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    favour1_d = favour1_q;
    jobA1_d   = jobA1_q;
    jobA2_d   = jobA2_q;
    jobAr_d   = jobAr_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    result_d  = result_q;
    mulStart  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = (req0 && req1) ? favour1_q : req1;
          jobA1_d = grant_d ? a1_1 : a1_0;
          jobA2_d = grant_d ? a2_1 : a2_0;
          jobAr_d = grant_d ? ar_1 : ar_0;
          state_d = GRANT;
        end
      end
      GRANT: state_d = READ;
      READ: begin
        opA_d   = rf_d1;
        opB_d   = rf_d2;
        state_d = MULT;
      end
      MULT: begin
        mulStart = !mulBusy;
        if (mulDone) state_d = WRITE;
      end
      WRITE: state_d = DONE;
      DONE: begin
        result_d  = mulP;
        favour1_d = ~grant_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign st_out  = state_q;
  assign ack0    = (state_q == DONE) && !grant_q;
  assign ack1    = (state_q == DONE) && grant_q;
  assign rf_adr1 = (state_q != IDLE) ? jobA1_q : '0;
  assign rf_adr2 = (state_q != IDLE) ? jobA2_q : '0;
  assign ram_we  = (state_q == WRITE);
  assign ram_adr = ram_we ? jobAr_q : '0;
  assign ram_wd  = ram_we ? mulP : '0;
  assign result  = result_q;

endmodule

// File: tb/tb_mult_job_arbiter.sv
// Directed self-checking bench for mult_job_arbiter with a behavioural regfile and RAM-write monitor.
module tb_mult_job_arbiter;

  localparam int DW = 4;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0, req1;
  logic [AW-1:0]   a1_0, a1_1, a2_0, a2_1, ar_0, ar_1;
  logic            ack0, ack1;
  logic [AW-1:0]   rf_adr1, rf_adr2;
  logic [DW-1:0]   rf_d1, rf_d2;
  logic            ram_we;
  logic [AW-1:0]   ram_adr;
  logic [2*DW-1:0] ram_wd;
  logic [2*DW-1:0] result;
  logic [2:0]      st_out;

  logic [DW-1:0]   rf [0:7];
  int              stTrace [0:12];
  int              checks = 0;
  int              fails = 0;

  assign rf_d1 = rf[rf_adr1];
  assign rf_d2 = rf[rf_adr2];

  always #5 clk = ~clk;

  mult_job_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a1_0(a1_0), .a1_1(a1_1), .a2_0(a2_0), .a2_1(a2_1), .ar_0(ar_0), .ar_1(ar_1),
    .ack0(ack0), .ack1(ack1), .rf_adr1(rf_adr1), .rf_adr2(rf_adr2),
    .rf_d1(rf_d1), .rf_d2(rf_d2), .ram_we(ram_we), .ram_adr(ram_adr), .ram_wd(ram_wd),
    .result(result), .st_out(st_out)
  );

  task automatic setFields(input int idx, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [AW-1:0] ar);
    if (idx == 0) begin a1_0 = a1; a2_0 = a2; ar_0 = ar; end
    else          begin a1_1 = a1; a2_1 = a2; ar_1 = ar; end
  endtask

  task automatic setReq(input int idx, input logic v);
    if (idx == 0) req0 = v; else req1 = v;
  endtask

  // Issues one job at the current negedge (cycle 0) and watches 12 cycles; the acked req is dropped at its ack.
  task automatic runJob(input int idx, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] ar, input int dropCycle,
                        output int ackCyc, output int otherAcks, output int weCount,
                        output logic [AW-1:0] wAdr, output logic [2*DW-1:0] wData);
    logic myAck, othAck;
    ackCyc = -1; otherAcks = 0; weCount = 0; wAdr = '0; wData = '0;
    setFields(idx, a1, a2, ar);
    setReq(idx, 1'b1);
    stTrace[0] = int'(st_out);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      stTrace[c] = int'(st_out);
      myAck  = (idx == 0) ? ack0 : ack1;
      othAck = (idx == 0) ? ack1 : ack0;
      if (myAck && ackCyc < 0) ackCyc = c;
      if (othAck) otherAcks++;
      if (ram_we) begin weCount++; wAdr = ram_adr; wData = ram_wd; end
      if (myAck || c == dropCycle) setReq(idx, 1'b0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; req0 = 0; req1 = 0;
    setFields(0, 0, 0, 0); setFields(1, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++; if (st_out !== 3'd0) begin fails++; $display("[TB] FAIL reset_state: got %0d expected 0", st_out); end
    checks++; if ({ack0, ack1, ram_we} !== 3'b000) begin fails++; $display("[TB] FAIL reset_strobes: got %b expected 000", {ack0, ack1, ram_we}); end
    checks++; if ({ram_adr, ram_wd, result, rf_adr1, rf_adr2} !== '0) begin fails++; $display("[TB] FAIL reset_buses: got %h expected 0", {ram_adr, ram_wd, result, rf_adr1, rf_adr2}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_job;
    int ackCyc, oth, we; logic [AW-1:0] wa; logic [2*DW-1:0] wd;
    int expSt [1:9];
    expSt = '{1, 2, 3, 3, 3, 3, 4, 5, 0};
    runJob(0, 3'd1, 3'd2, 3'd0, 0, ackCyc, oth, we, wa, wd);
    checks++; if (ackCyc != 8) begin fails++; $display("[TB] FAIL single_ack_latency: got %0d expected 8", ackCyc); end
    checks++; if (oth != 0) begin fails++; $display("[TB] FAIL single_other_ack: got %0d expected 0", oth); end
    checks++; if (we != 1) begin fails++; $display("[TB] FAIL single_we_count: got %0d expected 1", we); end
    checks++; if (wa !== 3'd0 || wd !== 8'd15) begin fails++; $display("[TB] FAIL single_write: got adr %0d wd %0d expected adr 0 wd 15", wa, wd); end
    checks++; if (result !== 8'd15) begin fails++; $display("[TB] FAIL single_result: got %0d expected 15", result); end
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (stTrace[c] != expSt[c]) begin fails++; $display("[TB] FAIL single_state_c%0d: got %0d expected %0d", c, stTrace[c], expSt[c]); end
    end
  endtask

  task automatic test_back_to_back;
    int ack0Cyc, ack1Cyc, nW;
    logic [AW-1:0] wAdrs [0:1];
    logic [2*DW-1:0] wDats [0:1];
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    ack0Cyc = -1; ack1Cyc = -1; nW = 0;
    wAdrs = '{default: '0}; wDats = '{default: '0};
    setFields(0, 3'd1, 3'd2, 3'd1);
    setFields(1, 3'd6, 3'd7, 3'd2);
    req0 = 1; req1 = 1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (ram_we) begin
        if (nW < 2) begin wAdrs[nW] = ram_adr; wDats[nW] = ram_wd; end
        nW++;
      end
      if (ack0 && ack0Cyc < 0) begin ack0Cyc = c; req0 = 0; end
      if (ack1 && ack1Cyc < 0) begin ack1Cyc = c; req1 = 0; end
    end
    checks++; if (ack0Cyc != 8) begin fails++; $display("[TB] FAIL b2b_ack0_cycle: got %0d expected 8", ack0Cyc); end
    checks++; if (ack1Cyc != 17) begin fails++; $display("[TB] FAIL b2b_ack1_cycle: got %0d expected 17", ack1Cyc); end
    checks++; if (nW != 2) begin fails++; $display("[TB] FAIL b2b_we_count: got %0d expected 2", nW); end
    checks++; if (wAdrs[0] !== 3'd1 || wDats[0] !== 8'd15) begin fails++; $display("[TB] FAIL b2b_first_write: got adr %0d wd %0d expected adr 1 wd 15", wAdrs[0], wDats[0]); end
    checks++; if (wAdrs[1] !== 3'd2 || wDats[1] !== 8'd14) begin fails++; $display("[TB] FAIL b2b_second_write: got adr %0d wd %0d expected adr 2 wd 14", wAdrs[1], wDats[1]); end
  endtask

  task automatic test_fairness;
    int order [0:3];
    int nAck;
    logic raise0, raise1;
    nAck = 0; raise0 = 0; raise1 = 0;
    order = '{default: -1};
    setFields(0, 3'd1, 3'd2, 3'd4);
    setFields(1, 3'd6, 3'd7, 3'd5);
    req0 = 1; req1 = 1;
    for (int c = 1; c <= 60 && nAck < 4; c++) begin
      @(negedge clk);
      if (raise0) begin req0 = 1; raise0 = 0; end
      if (raise1) begin req1 = 1; raise1 = 0; end
      if (ack0) begin order[nAck] = 0; nAck++; req0 = 0; raise0 = 1; end
      if (ack1) begin order[nAck] = 1; nAck++; req1 = 0; raise1 = 1; end
    end
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);
    checks++; if (nAck != 4) begin fails++; $display("[TB] FAIL fair_ack_count: got %0d expected 4", nAck); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (order[i] != (i % 2)) begin fails++; $display("[TB] FAIL fair_grant_%0d: got %0d expected %0d", i, order[i], i % 2); end
    end
    checks++; if (st_out !== 3'd0) begin fails++; $display("[TB] FAIL fair_idle_after: got %0d expected 0", st_out); end
  endtask

  task automatic test_boundary;
    int ackCyc, oth, we; logic [AW-1:0] wa; logic [2*DW-1:0] wd;
    runJob(0, 3'd3, 3'd4, 3'd5, 0, ackCyc, oth, we, wa, wd);
    checks++; if (we != 1 || wa !== 3'd5 || wd !== 8'hE1) begin fails++; $display("[TB] FAIL max_product: got we %0d adr %0d wd %0h expected we 1 adr 5 wd e1", we, wa, wd); end
    checks++; if (result !== 8'hE1) begin fails++; $display("[TB] FAIL max_result: got %0h expected e1", result); end
    runJob(1, 3'd0, 3'd5, 3'd7, 0, ackCyc, oth, we, wa, wd);
    checks++; if (we != 1 || wa !== 3'd7 || wd !== 8'd0) begin fails++; $display("[TB] FAIL zero_product: got we %0d adr %0d wd %0d expected we 1 adr 7 wd 0", we, wa, wd); end
    checks++; if (ackCyc != 8) begin fails++; $display("[TB] FAIL zero_ack1: got %0d expected 8", ackCyc); end
    checks++; if (result !== 8'd0) begin fails++; $display("[TB] FAIL zero_result: got %0d expected 0", result); end
  endtask

  task automatic test_reset_mid_job;
    int stBefore, weCnt, ackCnt, ackCyc, oth, we; logic [AW-1:0] wa; logic [2*DW-1:0] wd;
    weCnt = 0; ackCnt = 0; stBefore = -1;
    setFields(0, 3'd1, 3'd2, 3'd6);
    req0 = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      stBefore = int'(st_out);
    end
    checks++; if (stBefore != 3) begin fails++; $display("[TB] FAIL midrst_in_mult: got %0d expected 3", stBefore); end
    rst = 0; req0 = 0;
    #1;
    checks++; if (st_out !== 3'd0) begin fails++; $display("[TB] FAIL midrst_state: got %0d expected 0", st_out); end
    @(negedge clk);
    rst = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ram_we) weCnt++;
      if (ack0 || ack1) ackCnt++;
    end
    checks++; if (weCnt != 0 || ackCnt != 0) begin fails++; $display("[TB] FAIL midrst_discard: got we %0d ack %0d expected 0 0", weCnt, ackCnt); end
    runJob(0, 3'd1, 3'd2, 3'd6, 0, ackCyc, oth, we, wa, wd);
    checks++; if (ackCyc != 8 || we != 1 || wa !== 3'd6 || wd !== 8'd15) begin fails++; $display("[TB] FAIL midrst_reissue: got ack %0d we %0d adr %0d wd %0d expected 8 1 6 15", ackCyc, we, wa, wd); end
  endtask

  task automatic test_dropped_req;
    int ackCyc, oth, we; logic [AW-1:0] wa; logic [2*DW-1:0] wd;
    runJob(1, 3'd6, 3'd7, 3'd3, 2, ackCyc, oth, we, wa, wd);
    checks++; if (ackCyc != 8) begin fails++; $display("[TB] FAIL drop_ack1: got %0d expected 8", ackCyc); end
    checks++; if (we != 1 || wa !== 3'd3 || wd !== 8'd14) begin fails++; $display("[TB] FAIL drop_write: got we %0d adr %0d wd %0d expected 1 3 14", we, wa, wd); end
    checks++; if (oth != 0 || result !== 8'd14) begin fails++; $display("[TB] FAIL drop_result: got ack0s %0d result %0d expected 0 14", oth, result); end
  endtask

  initial begin
    rf[0] = 4'd0;  rf[1] = 4'd3;  rf[2] = 4'd5; rf[3] = 4'd15;
    rf[4] = 4'd15; rf[5] = 4'd9;  rf[6] = 4'd7; rf[7] = 4'd2;
    test_reset();
    test_single_job();
    test_back_to_back();
    test_fairness();
    test_boundary();
    test_reset_mid_job();
    test_dropped_req();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
